// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the riscv instruction-fetch front end.
package riscv_fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous flushable FIFO of fetched {pc, inst} entries; synchronous active-low reset.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: req/gnt/rvalid imem handshake into a prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned        CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] last_pc_q;

  entry_t          head, push_data;
  logic            fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic            push, pop, flush, bypass;

  assign push_data = '{pc: req_pc_q, inst: imem_rdata_i};
  assign pop       = ~fifo_empty & inst_ready_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & (state_q == WAIT) & imem_rvalid_i & ~redirect_i;
`else
  assign bypass = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: if (!fifo_full) state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          push    = ~(bypass & inst_ready_i);
          state_d = ((fifo_count + CNT_W'(push)) - CNT_W'(pop)) < FULL_CNT ? REQ : IDLE;
        end
      end
      DROP: if (imem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect wins; a granted-but-unanswered request must still be drained in DROP.
    if (redirect_i) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      unique case (state_q)
        REQ:        state_d = imem_gnt_i ? DROP : REQ;
        WAIT, DROP: state_d = imem_rvalid_i ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end
  end

  always_comb begin
    inst_valid_o = ~fifo_empty | bypass;
    inst_o       = NOP_INST;
    inst_pc_o    = last_pc_q;
    if (!fifo_empty) begin
      inst_o    = head.inst;
      inst_pc_o = head.pc;
    end else if (bypass) begin
      inst_o    = imem_rdata_i;
      inst_pc_o = req_pc_q;
    end
  end

  assign imem_addr_o = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      if (inst_valid_o) last_pc_q <= inst_pc_o;
    end
  end

endmodule
